// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter: two-requester round-robin APB master sharing one bus.
// Sequences each granted transfer through IDLE/SETUP/ACCESS and returns
// read data and status to the owner. Optional ACCESS timeout: APB_TIMEOUT_EN.
// Ports: PCLK/PRESET; req/addr/write/wdata in, done/rdata/err out per
// requester (0 = CPU LSU, 1 = DMA); PADDR/PWRITE/PWDATA/PSEL/PENABLE out,
// PRDATA/PREADY in.
module apb_master_arbiter #(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic              PCLK,
   input  logic              PRESET,
   input  logic              req0,
   input  logic              req1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic              write0,
   input  logic              write1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              done0,
   output logic              done1,
   output logic [DATA_W-1:0] rdata0,
   output logic [DATA_W-1:0] rdata1,
   output logic              err0,
   output logic              err1,
   output logic [ADDR_W-1:0] PADDR,
   output logic              PWRITE,
   output logic [DATA_W-1:0] PWDATA,
   output logic              PSEL,
   output logic              PENABLE,
   input  logic [DATA_W-1:0] PRDATA,
   input  logic              PREADY
);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] paddr_q, paddr_d;
   logic              pwrite_q, pwrite_d;
   logic [DATA_W-1:0] pwdata_q, pwdata_d;
   logic              psel_q, psel_d;
   logic              penable_q, penable_d;
   logic              done0_q, done0_d;
   logic              done1_q, done1_d;
   logic [DATA_W-1:0] rdata0_q, rdata0_d;
   logic [DATA_W-1:0] rdata1_q, rdata1_d;
   logic              gnt_q, gnt_d;
   logic              last_q, last_d;
   logic              elig0, elig1, sel;

`ifdef APB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err0_q, err0_d;
   logic             err1_q, err1_d;
`endif

   // A requester still high in its own done cycle is not a new request.
   assign elig0 = req0 & ~done0_q;
   assign elig1 = req1 & ~done1_q;
   assign sel   = (elig0 & elig1) ? ~last_q : elig1;

   always_comb begin
      state_d   = state_q;
      paddr_d   = paddr_q;
      pwrite_d  = pwrite_q;
      pwdata_d  = pwdata_q;
      psel_d    = psel_q;
      penable_d = penable_q;
      done0_d   = 1'b0;
      done1_d   = 1'b0;
      rdata0_d  = rdata0_q;
      rdata1_d  = rdata1_q;
      gnt_d     = gnt_q;
      last_d    = last_q;
`ifdef APB_TIMEOUT_EN
      cnt_d     = cnt_q;
      err0_d    = err0_q;
      err1_d    = err1_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (elig0 | elig1) begin
               gnt_d     = sel;
               last_d    = sel;
               paddr_d   = sel ? addr1 : addr0;
               pwrite_d  = sel ? write1 : write0;
               pwdata_d  = sel ? wdata1 : wdata0;
               psel_d    = 1'b1;
               penable_d = 1'b0;
               state_d   = SETUP;
`ifdef APB_TIMEOUT_EN
               cnt_d     = '0;
`endif
            end
         end
         SETUP: begin
            penable_d = 1'b1;
            state_d   = ACCESS;
         end
         ACCESS: begin
            if (PREADY) begin
               psel_d    = 1'b0;
               penable_d = 1'b0;
               state_d   = IDLE;
               if (gnt_q) begin
                  done1_d = 1'b1;
                  if (!pwrite_q) rdata1_d = PRDATA;
`ifdef APB_TIMEOUT_EN
                  err1_d  = 1'b0;
`endif
               end else begin
                  done0_d = 1'b1;
                  if (!pwrite_q) rdata0_d = PRDATA;
`ifdef APB_TIMEOUT_EN
                  err0_d  = 1'b0;
`endif
               end
            end
`ifdef APB_TIMEOUT_EN
            // Last allowed cycle without PREADY: abort with error.
            else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               psel_d    = 1'b0;
               penable_d = 1'b0;
               state_d   = IDLE;
               if (gnt_q) begin
                  done1_d  = 1'b1;
                  err1_d   = 1'b1;
                  rdata1_d = DATA_W'(32'hDEAD_BEEF);
               end else begin
                  done0_d  = 1'b1;
                  err0_d   = 1'b1;
                  rdata0_d = DATA_W'(32'hDEAD_BEEF);
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         state_q   <= IDLE;
         paddr_q   <= '0;
         pwrite_q  <= 1'b0;
         pwdata_q  <= '0;
         psel_q    <= 1'b0;
         penable_q <= 1'b0;
         done0_q   <= 1'b0;
         done1_q   <= 1'b0;
         rdata0_q  <= '0;
         rdata1_q  <= '0;
         gnt_q     <= 1'b0;
         last_q    <= 1'b1;
`ifdef APB_TIMEOUT_EN
         cnt_q     <= '0;
         err0_q    <= 1'b0;
         err1_q    <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         paddr_q   <= paddr_d;
         pwrite_q  <= pwrite_d;
         pwdata_q  <= pwdata_d;
         psel_q    <= psel_d;
         penable_q <= penable_d;
         done0_q   <= done0_d;
         done1_q   <= done1_d;
         rdata0_q  <= rdata0_d;
         rdata1_q  <= rdata1_d;
         gnt_q     <= gnt_d;
         last_q    <= last_d;
`ifdef APB_TIMEOUT_EN
         cnt_q     <= cnt_d;
         err0_q    <= err0_d;
         err1_q    <= err1_d;
`endif
      end
   end

   assign PADDR   = paddr_q;
   assign PWRITE  = pwrite_q;
   assign PWDATA  = pwdata_q;
   assign PSEL    = psel_q;
   assign PENABLE = penable_q;
   assign done0   = done0_q;
   assign done1   = done1_q;
   assign rdata0  = rdata0_q;
   assign rdata1  = rdata1_q;
`ifdef APB_TIMEOUT_EN
   assign err0    = err0_q;
   assign err1    = err1_q;
`else
   assign err0    = 1'b0;
   assign err1    = 1'b0;
`endif

endmodule

// File: tb/tb_apb_master_arbiter.sv
// tb_apb_master_arbiter: directed and randomized checks of the APB arbiter
// against a transaction-level model of arbitration, timing and slave memory.
module tb_apb_master_arbiter;
   localparam int AW = 32;
   localparam int DW = 32;

   logic          PCLK = 1'b0;
   logic          PRESET;
   logic          req [2];
   logic [AW-1:0] addr [2];
   logic          wr [2];
   logic [DW-1:0] wd [2];
   logic          done [2];
   logic [DW-1:0] rdata [2];
   logic          err [2];
   logic [AW-1:0] PADDR;
   logic          PWRITE;
   logic [DW-1:0] PWDATA;
   logic          PSEL, PENABLE;
   logic [DW-1:0] PRDATA;
   logic          PREADY;

   int nvec = 0;
   int nerr = 0;
   int exp_last = 1;
   int grant_log [$];

   int            slv_wait = 0;
   bit            slv_stall = 1'b0;
   int            acc_cnt = 0;
   logic [DW-1:0] mem [16];
   logic [DW-1:0] exp_mem [16];

   always #5 PCLK = ~PCLK;

   apb_master_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(16)) dut (
      .PCLK(PCLK), .PRESET(PRESET),
      .req0(req[0]), .req1(req[1]),
      .addr0(addr[0]), .addr1(addr[1]),
      .write0(wr[0]), .write1(wr[1]),
      .wdata0(wd[0]), .wdata1(wd[1]),
      .done0(done[0]), .done1(done[1]),
      .rdata0(rdata[0]), .rdata1(rdata[1]),
      .err0(err[0]), .err1(err[1]),
      .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA),
      .PSEL(PSEL), .PENABLE(PENABLE),
      .PRDATA(PRDATA), .PREADY(PREADY)
   );

   function automatic logic [DW-1:0] init_word(int i);
      if (i == 1) return 32'h0000_005A;
      return (32'(i) * 32'h0101_0101) ^ 32'hC3A5_0000;
   endfunction

   // Simple memory slave: PREADY after slv_wait low ACCESS cycles.
   assign PREADY = PSEL & PENABLE & ~slv_stall & (acc_cnt >= slv_wait);
   assign PRDATA = mem[PADDR[5:2]];

   always @(posedge PCLK) begin
      if (PRESET) begin
         acc_cnt <= 0;
         for (int i = 0; i < 16; i++) mem[i] <= init_word(i);
      end else begin
         if (PSEL && PENABLE && !PREADY) acc_cnt <= acc_cnt + 1;
         else acc_cnt <= 0;
         if (PSEL && PENABLE && PREADY && PWRITE)
            mem[PADDR[5:2]] <= PWDATA;
      end
   end

   task automatic tick();
      @(posedge PCLK);
      #1;
   endtask

   task automatic test_reset();
      PRESET = 1'b1;
      slv_wait = 0;
      slv_stall = 1'b0;
      for (int r = 0; r < 2; r++) begin
         req[r] = 1'b0; addr[r] = '0; wr[r] = 1'b0; wd[r] = '0;
      end
      repeat (2) @(posedge PCLK);
      #1;
      nvec++;
      if ({PSEL, PENABLE, PWRITE} !== 3'b000) begin
         nerr++;
         $display("FAIL reset_ctrl: got %b want 000", {PSEL, PENABLE, PWRITE});
      end
      nvec++;
      if ({PADDR, PWDATA} !== 64'd0) begin
         nerr++;
         $display("FAIL reset_bus: got %h want 0", {PADDR, PWDATA});
      end
      nvec++;
      if ({done[0], done[1], err[0], err[1]} !== 4'b0000) begin
         nerr++;
         $display("FAIL reset_flags: got %b want 0000",
                  {done[0], done[1], err[0], err[1]});
      end
      nvec++;
      if ({rdata[0], rdata[1]} !== 64'd0) begin
         nerr++;
         $display("FAIL reset_rdata: got %h want 0", {rdata[0], rdata[1]});
      end
      PRESET = 1'b0;
      exp_last = 1;
      for (int i = 0; i < 16; i++) exp_mem[i] = init_word(i);
   endtask

   task automatic test_single_read();
      slv_wait = 1;
      req[0] = 1'b1; addr[0] = 32'h4; wr[0] = 1'b0; wd[0] = $urandom;
      tick();
      nvec++;
      if ({PSEL, PENABLE, PWRITE} !== 3'b100 || PADDR !== 32'h4) begin
         nerr++;
         $display("FAIL rd_setup: got %b/%h want 100/4",
                  {PSEL, PENABLE, PWRITE}, PADDR);
      end
      tick();
      nvec++;
      if ({PSEL, PENABLE} !== 2'b11) begin
         nerr++;
         $display("FAIL rd_access: got %b want 11", {PSEL, PENABLE});
      end
      tick();
      nvec++;
      if (done[0] !== 1'b0) begin
         nerr++;
         $display("FAIL rd_early_done: got %b want 0", done[0]);
      end
      tick();
      nvec++;
      if ({done[0], done[1], err[0], PSEL, PENABLE} !== 5'b10000) begin
         nerr++;
         $display("FAIL rd_done: got %b want 10000",
                  {done[0], done[1], err[0], PSEL, PENABLE});
      end
      nvec++;
      if (rdata[0] !== 32'h5A) begin
         nerr++;
         $display("FAIL rd_data: got %h want 0000005a", rdata[0]);
      end
      req[0] = 1'b0;
      exp_last = 0;
   endtask

   task automatic test_single_write();
      slv_wait = 0;
      req[1] = 1'b1; addr[1] = 32'h0; wr[1] = 1'b1; wd[1] = 32'hFF;
      tick();
      nvec++;
      if ({PSEL, PENABLE, PWRITE} !== 3'b101 || PWDATA !== 32'hFF
          || PADDR !== 32'h0) begin
         nerr++;
         $display("FAIL wr_setup: got %b/%h want 101/ff",
                  {PSEL, PENABLE, PWRITE}, PWDATA);
      end
      tick();
      nvec++;
      if ({PSEL, PENABLE, PWRITE} !== 3'b111 || PWDATA !== 32'hFF) begin
         nerr++;
         $display("FAIL wr_access: got %b/%h want 111/ff",
                  {PSEL, PENABLE, PWRITE}, PWDATA);
      end
      tick();
      nvec++;
      if ({done[1], done[0], err[1], PSEL} !== 4'b1000) begin
         nerr++;
         $display("FAIL wr_done: got %b want 1000",
                  {done[1], done[0], err[1], PSEL});
      end
      nvec++;
      if (rdata[1] !== 32'h0) begin
         nerr++;
         $display("FAIL wr_rdata_hold: got %h want 0", rdata[1]);
      end
      req[1] = 1'b0;
      exp_mem[0] = 32'hFF;
      exp_last = 1;
   endtask

   task automatic test_hold_req();
      slv_wait = 0;
      req[0] = 1'b1; addr[0] = 32'h8; wr[0] = 1'b0;
      repeat (3) tick();
      nvec++;
      if (done[0] !== 1'b1 || rdata[0] !== exp_mem[2]) begin
         nerr++;
         $display("FAIL hold_done: got %b/%h want 1/%h",
                  done[0], rdata[0], exp_mem[2]);
      end
      tick();
      nvec++;
      if (PSEL !== 1'b0) begin
         nerr++;
         $display("FAIL hold_no_reissue: got %b want 0", PSEL);
      end
      req[0] = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         nvec++;
         if (PSEL !== 1'b0 || PADDR !== 32'h8) begin
            nerr++;
            $display("FAIL hold_idle: got %b/%h want 0/8", PSEL, PADDR);
         end
      end
      exp_last = 0;
   endtask

   task automatic test_reset_mid();
      slv_stall = 1'b1;
      req[0] = 1'b1; addr[0] = 32'hC; wr[0] = 1'b0;
      repeat (3) tick();
      #2;
      PRESET = 1'b1;
      #1;
      nvec++;
      if ({PSEL, PENABLE, done[0]} !== 3'b000) begin
         nerr++;
         $display("FAIL rst_mid_bus: got %b want 000",
                  {PSEL, PENABLE, done[0]});
      end
      tick();
      nvec++;
      if ({PSEL, done[0], done[1]} !== 3'b000) begin
         nerr++;
         $display("FAIL rst_mid_hold: got %b want 000",
                  {PSEL, done[0], done[1]});
      end
      PRESET = 1'b0;
      slv_stall = 1'b0;
      slv_wait = 0;
      exp_last = 1;
      for (int i = 0; i < 16; i++) exp_mem[i] = init_word(i);
      tick();
      nvec++;
      if ({PSEL, PENABLE} !== 2'b10) begin
         nerr++;
         $display("FAIL rst_mid_reissue: got %b want 10", {PSEL, PENABLE});
      end
      repeat (2) tick();
      nvec++;
      if (done[0] !== 1'b1 || rdata[0] !== exp_mem[3]) begin
         nerr++;
         $display("FAIL rst_mid_done: got %b/%h want 1/%h",
                  done[0], rdata[0], exp_mem[3]);
      end
      req[0] = 1'b0;
      exp_last = 0;
   endtask

   task automatic test_timeout();
`ifdef APB_TIMEOUT_EN
      slv_stall = 1'b1;
      req[1] = 1'b1; addr[1] = 32'h10; wr[1] = 1'b0;
      repeat (2) tick();
      for (int i = 1; i <= 16; i++) begin
         tick();
         if (i < 16) begin
            nvec++;
            if ({done[1], PSEL} !== 2'b01) begin
               nerr++;
               $display("FAIL to_wait%0d: got %b want 01", i, {done[1], PSEL});
            end
         end
      end
      nvec++;
      if ({done[1], err[1], PSEL} !== 3'b110 || rdata[1] !== 32'hDEADBEEF) begin
         nerr++;
         $display("FAIL to_abort: got %b/%h want 110/deadbeef",
                  {done[1], err[1], PSEL}, rdata[1]);
      end
      req[1] = 1'b0;
      slv_stall = 1'b0;
      tick();
      slv_wait = 15;
      req[0] = 1'b1; addr[0] = 32'h14; wr[0] = 1'b0;
      repeat (2) tick();
      for (int i = 1; i <= 16; i++) begin
         tick();
         if (i < 16) begin
            nvec++;
            if (done[0] !== 1'b0) begin
               nerr++;
               $display("FAIL to_edge_wait%0d: got %b want 0", i, done[0]);
            end
         end
      end
      nvec++;
      if ({done[0], err[0]} !== 2'b10 || rdata[0] !== exp_mem[5]) begin
         nerr++;
         $display("FAIL to_edge_ready: got %b/%h want 10/%h",
                  {done[0], err[0]}, rdata[0], exp_mem[5]);
      end
      req[0] = 1'b0;
`else
      bit seen_done;
      seen_done = 1'b0;
      slv_stall = 1'b1;
      req[1] = 1'b1; addr[1] = 32'h10; wr[1] = 1'b0;
      repeat (40) begin
         tick();
         if (done[1] || err[1]) seen_done = 1'b1;
      end
      nvec++;
      if ({PSEL, PENABLE, seen_done} !== 3'b110) begin
         nerr++;
         $display("FAIL no_timeout: got %b want 110",
                  {PSEL, PENABLE, seen_done});
      end
      req[1] = 1'b0;
`endif
      test_reset();
   endtask

   // Transaction-level model: grant rule, phase timing and slave memory.
   task automatic run_traffic(int ncyc, int p_req);
      bit            m_busy = 1'b0;
      int            m_t = 0;
      int            m_wait = 0;
      int            g = 0;
      bit            snap [2];
      bit            exp_done [2];
      int            c = 0;
      while (c < ncyc || req[0] || req[1] || m_busy) begin
         if (c >= ncyc + 200) begin
            nvec++; nerr++;
            $display("FAIL drain_timeout: got busy want idle");
            break;
         end
         snap[0] = req[0];
         snap[1] = req[1];
         tick();
         exp_done[0] = 1'b0;
         exp_done[1] = 1'b0;
         if (m_busy) begin
            m_t++;
            if (m_t == m_wait + 2) begin
               exp_done[g] = 1'b1;
               m_busy = 1'b0;
            end
         end else if (snap[0] || snap[1]) begin
            g = (snap[0] && snap[1]) ? 1 - exp_last : (snap[0] ? 0 : 1);
            exp_last = g;
            m_busy = 1'b1;
            m_t = 0;
            m_wait = slv_wait;
            nvec++;
            if (PADDR !== addr[g] || PWRITE !== wr[g] || PWDATA !== wd[g]) begin
               nerr++;
               $display("FAIL grant_fields: got %h/%b/%h want %h/%b/%h (req%0d)",
                        PADDR, PWRITE, PWDATA, addr[g], wr[g], wd[g], g);
            end
         end
         nvec++;
         if ({PSEL, PENABLE} !== {m_busy, m_busy && m_t >= 1}) begin
            nerr++;
            $display("FAIL phase: got %b want %b", {PSEL, PENABLE},
                     {m_busy, m_busy && m_t >= 1});
         end
         nvec++;
         if ({done[1], done[0]} !== {exp_done[1], exp_done[0]}) begin
            nerr++;
            $display("FAIL done: got %b want %b", {done[1], done[0]},
                     {exp_done[1], exp_done[0]});
         end
         for (int r = 0; r < 2; r++) begin
            if (done[r]) grant_log.push_back(r);
            if (exp_done[r]) begin
               nvec++;
               if (err[r] !== 1'b0) begin
                  nerr++;
                  $display("FAIL err%0d: got %b want 0", r, err[r]);
               end
               if (wr[r]) begin
                  exp_mem[addr[r][5:2]] = wd[r];
               end else begin
                  nvec++;
                  if (rdata[r] !== exp_mem[addr[r][5:2]]) begin
                     nerr++;
                     $display("FAIL rdata%0d: got %h want %h", r, rdata[r],
                              exp_mem[addr[r][5:2]]);
                  end
               end
               req[r] = 1'b0;
            end
         end
         for (int r = 0; r < 2; r++) begin
            if (c < ncyc && !exp_done[r] && !req[r]
                && $urandom_range(99) < p_req) begin
               req[r] = 1'b1;
               addr[r] = AW'($urandom_range(15)) << 2;
               wr[r] = 1'($urandom_range(1));
               wd[r] = $urandom;
            end
         end
         if (!m_busy) slv_wait = $urandom_range(3);
         c++;
      end
   endtask

   task automatic test_contention();
      test_reset();
      grant_log.delete();
      run_traffic(60, 100);
      nvec++;
      if (grant_log.size() < 4) begin
         nerr++;
         $display("FAIL cont_count: got %0d want >=4", grant_log.size());
      end
      for (int i = 0; i < grant_log.size(); i++) begin
         nvec++;
         if (grant_log[i] != i % 2) begin
            nerr++;
            $display("FAIL cont_order[%0d]: got %0d want %0d",
                     i, grant_log[i], i % 2);
         end
      end
   endtask

   task automatic test_random();
      test_reset();
      run_traffic(800, 30);
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_single_write();
      test_hold_req();
      test_reset_mid();
      test_timeout();
      test_contention();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
